// File: rtl/median_pkg.sv
// Shared defaults and FSM state encoding for the block order-statistic engine.
package median_pkg;

  localparam int DEF_D_WIDTH = 8;
  localparam int DEF_A_WIDTH = 8;
  localparam int DEF_R_WIDTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/median_sort_ins.sv
// Insertion-sorted register array: each valid sample lands in its ascending slot
// in one cycle; equal values are placed after existing copies.
module median_sort_ins
  import median_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int R_WIDTH = DEF_R_WIDTH,
  parameter int SIGNED  = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ins_vld_i,
  input  logic [D_WIDTH-1:0] ins_data_i,
  input  logic               clr_i,
  input  logic [R_WIDTH-1:0] rd_idx_i,
  output logic [D_WIDTH-1:0] rd_data_o
);

  localparam int BLK = 1 << R_WIDTH;

  logic [BLK-1:0]              vld_q;
  logic [BLK-1:0][D_WIDTH-1:0] data_q;
  logic [BLK-1:0][D_WIDTH-1:0] data_d;
  logic [BLK-1:0]              keep;

  // Extending by one bit lets one signed compare serve both number formats.
  function automatic logic le(input logic [D_WIDTH-1:0] a, input logic [D_WIDTH-1:0] b);
    logic signed [D_WIDTH:0] sa;
    logic signed [D_WIDTH:0] sb;
    if (SIGNED != 0) begin
      sa = {a[D_WIDTH-1], a};
      sb = {b[D_WIDTH-1], b};
    end else begin
      sa = {1'b0, a};
      sb = {1'b0, b};
    end
    return sa <= sb;
  endfunction

  always_comb begin
    keep = '0;
    for (int j = 0; j < BLK; j++) begin
      keep[j] = vld_q[j] && le(data_q[j], ins_data_i);
    end
    data_d    = data_q;
    data_d[0] = keep[0] ? data_q[0] : ins_data_i;
    for (int j = 1; j < BLK; j++) begin
      if (keep[j])          data_d[j] = data_q[j];
      else if (keep[j-1])   data_d[j] = ins_data_i;
      else                  data_d[j] = data_q[j-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      data_q <= '0;
    end else if (clr_i) begin
      vld_q  <= '0;
      data_q <= '0;
    end else if (ins_vld_i) begin
      vld_q  <= {vld_q[BLK-2:0], 1'b1};
      data_q <= data_d;
    end
  end

  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/median_rank_engine.sv
// Streams fixed-size blocks from an input memory, ranks each block and writes the
// selected order statistic per block to an output memory.
module median_rank_engine
  import median_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int R_WIDTH = DEF_R_WIDTH,
  parameter int SIGNED  = 0
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Go_t,
  input  logic [R_WIDTH-1:0]         Rank,
  input  logic [A_WIDTH-R_WIDTH:0]   NBlk,
  output logic [A_WIDTH-1:0]         MA_Addr,
  output logic                       MA_en,
  input  logic [D_WIDTH-1:0]         MA_do,
  output logic [A_WIDTH-R_WIDTH-1:0] MO_Addr,
  output logic [D_WIDTH-1:0]         MO_di,
  output logic                       MO_en,
  output logic                       MO_we,
  output logic                       Busy,
  output logic                       Done_t
);

  localparam int B_WIDTH = A_WIDTH - R_WIDTH;
  localparam int NB_W    = B_WIDTH + 1;
  localparam logic [NB_W-1:0]    NB_MAX  = {1'b1, {B_WIDTH{1'b0}}};
  localparam logic [NB_W-1:0]    BLK_ONE = NB_W'(1);
  localparam logic [R_WIDTH-1:0] SMP_ONE = R_WIDTH'(1);

  state_e             state_q;
  logic [R_WIDTH-1:0] rank_q;
  logic [NB_W-1:0]    nblk_q;
  logic [NB_W-1:0]    blk_q;
  logic [R_WIDTH-1:0] smp_q;
  logic               rd_vld_q;

  logic [NB_W-1:0]    blk_nxt;
  logic [NB_W-1:0]    nblk_lim;
  logic [D_WIDTH-1:0] srt_data;

  assign blk_nxt  = blk_q + BLK_ONE;
  assign nblk_lim = (NBlk > NB_MAX) ? NB_MAX : NBlk;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_IDLE;
      rank_q   <= '0;
      nblk_q   <= '0;
      blk_q    <= '0;
      smp_q    <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      // Read data returns one cycle after its request; this flag marks it for insertion.
      rd_vld_q <= (state_q == ST_READ);
      case (state_q)
        ST_IDLE: begin
          if (Go_t) begin
            rank_q  <= Rank;
            nblk_q  <= nblk_lim;
            blk_q   <= '0;
            smp_q   <= '0;
            state_q <= (nblk_lim == '0) ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          smp_q <= smp_q + SMP_ONE;
          if (&smp_q) state_q <= ST_CAPT;
        end
        ST_CAPT:  state_q <= ST_WRITE;
        ST_WRITE: begin
          if (blk_nxt < nblk_q) begin
            blk_q   <= blk_nxt;
            state_q <= ST_READ;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  median_sort_ins #(
    .D_WIDTH (D_WIDTH),
    .R_WIDTH (R_WIDTH),
    .SIGNED  (SIGNED)
  ) u_sort (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .ins_vld_i  (rd_vld_q),
    .ins_data_i (MA_do),
    .clr_i      (state_q == ST_WRITE),
    .rd_idx_i   (rank_q),
    .rd_data_o  (srt_data)
  );

  // Outputs decode only registered state, and are gated so idle/reset shows all zeros.
  always_comb begin
    MA_en   = (state_q == ST_READ);
    MA_Addr = MA_en ? {blk_q[B_WIDTH-1:0], smp_q} : '0;
    MO_we   = (state_q == ST_WRITE);
    MO_en   = MO_we;
    MO_Addr = MO_we ? blk_q[B_WIDTH-1:0] : '0;
    MO_di   = MO_we ? srt_data : '0;
    Busy    = (state_q == ST_READ) || (state_q == ST_CAPT) || (state_q == ST_WRITE);
    Done_t  = (state_q == ST_DONE);
  end

endmodule
